pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 31 +++
 rtl/pipeline_ctrl.sv | 104 ++++++++++
 tb/tb_pipeline_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_ctrl.
// The slave modport is the controller's view; master is the datapath side.
interface pipeline_ctrl_if;
    logic ID_LoadUse;
    logic EX_DivStart;
    logic MEM_MemReq;
    logic MEM_MemReady;
    logic EX_BranchTaken;
    logic MEM_Exception;
    logic PC_Stall;
    logic IF_ID_Stall;
    logic ID_EX_Stall;
    logic EX_MEM_Stall;
    logic IF_ID_Flush;
    logic ID_EX_Flush;
    logic EX_MEM_Flush;
    logic MEM_WB_Flush;
    logic Div_Busy;
    logic Bus_Error;

    modport master (
        output ID_LoadUse, EX_DivStart, MEM_MemReq, MEM_MemReady, EX_BranchTaken, MEM_Exception,
        input  PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, Div_Busy, Bus_Error
    );
    modport slave (
        input  ID_LoadUse, EX_DivStart, MEM_MemReq, MEM_MemReady, EX_BranchTaken, MEM_Exception,
        output PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, Div_Busy, Bus_Error
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall/flush generation for exceptions, memory waits,
// multi-cycle division, load-use and branches. PIPE_CTRL_TIMEOUT_EN adds a memory-wait bus timeout.
module pipeline_ctrl (
    input logic            clock,
    input logic            reset,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic {RUN, DIV_WAIT} state_t;

    state_t     r_state, w_state_nxt;
    logic [4:0] r_div_cnt, w_div_cnt_nxt;
    logic       w_memwait, w_exc, w_timeout, w_div_run, w_div_start;
    logic       w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall;
    logic       w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush;

    assign w_memwait   = bus.MEM_MemReq && !bus.MEM_MemReady;
    assign w_exc       = bus.MEM_Exception || w_timeout;
    assign w_div_run   = (r_state == DIV_WAIT) && (r_div_cnt != 5'd0);
    // A new division is only accepted when nothing of higher priority claims the cycle.
    assign w_div_start = (r_state == RUN) && bus.EX_DivStart && !w_exc && !w_memwait;

`ifdef PIPE_CTRL_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    assign w_timeout = w_memwait && (r_wait_cnt == 8'hFF);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       r_wait_cnt <= 8'd0;
        else if (w_timeout || !w_memwait) r_wait_cnt <= 8'd0;
        else if (r_wait_cnt != 8'hFF)     r_wait_cnt <= r_wait_cnt + 8'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= RUN;
            r_div_cnt <= 5'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_idex_stall  = 1'b0;
        w_exmem_stall = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;

        // The divider keeps counting underneath memory waits.
        if (r_state == DIV_WAIT) begin
            if (r_div_cnt != 5'd0) w_div_cnt_nxt = r_div_cnt - 5'd1;
            else                   w_state_nxt   = RUN;
        end

        if (w_exc) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_state_nxt   = RUN;
            w_div_cnt_nxt = 5'd0;
        end else if (w_memwait) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_memwb_flush = 1'b1;
        end else if (w_div_run || w_div_start) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_flush = 1'b1;
            if (w_div_start) begin
                w_state_nxt   = DIV_WAIT;
                w_div_cnt_nxt = 5'd31;
            end
        end else if (bus.ID_LoadUse) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
        end else if (bus.EX_BranchTaken) begin
            w_ifid_flush = 1'b1;
        end
    end

    assign bus.PC_Stall     = w_pc_stall;
    assign bus.IF_ID_Stall  = w_ifid_stall;
    assign bus.ID_EX_Stall  = w_idex_stall;
    assign bus.EX_MEM_Stall = w_exmem_stall;
    assign bus.IF_ID_Flush  = w_ifid_flush;
    assign bus.ID_EX_Flush  = w_idex_flush;
    assign bus.EX_MEM_Flush = w_exmem_flush;
    assign bus.MEM_WB_Flush = w_memwb_flush;
    assign bus.Div_Busy     = w_div_run || w_div_start;
    assign bus.Bus_Error    = w_timeout;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle priority table plus multi-cycle
// sequences for division, memory wait, exception, reset and bus timeout.
module tb_pipeline_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipeline_ctrl_if bus();
    pipeline_ctrl dut (.clock(clock), .reset(reset), .bus(bus.slave));

    // inputs:  {LoadUse, DivStart, MemReq, MemReady, Branch, Exception}
    // outputs: {PC_S, IFID_S, IDEX_S, EXMEM_S, IFID_F, IDEX_F, EXMEM_F, MEMWB_F, Div_Busy, Bus_Error}
    typedef struct packed {
        logic [5:0] in;
        logic [9:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [9:0] outs();
        return {bus.PC_Stall, bus.IF_ID_Stall, bus.ID_EX_Stall, bus.EX_MEM_Stall,
                bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EX_MEM_Flush, bus.MEM_WB_Flush,
                bus.Div_Busy, bus.Bus_Error};
    endfunction

    task automatic drive(input logic [5:0] v);
        {bus.ID_LoadUse, bus.EX_DivStart, bus.MEM_MemReq, bus.MEM_MemReady,
         bus.EX_BranchTaken, bus.MEM_Exception} = v;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fresh_reset();
        @(posedge clock); #1;
        drive(6'b0);
        reset = 1'b0;
        #1 reset = 1'b1;
    endtask

    vec_t tbl[13];

    initial begin
        int c_pc, c_busy, c_err, err_k;
        logic [9:0] err_out;

        tbl[0]  = '{6'b000000, 10'b0000_0000_00}; // idle
        tbl[1]  = '{6'b000001, 10'b0000_1110_00}; // exception
        tbl[2]  = '{6'b001000, 10'b1111_0001_00}; // memory wait
        tbl[3]  = '{6'b001100, 10'b0000_0000_00}; // memory ready
        tbl[4]  = '{6'b010000, 10'b1110_0010_10}; // div start
        tbl[5]  = '{6'b100000, 10'b1100_0100_00}; // load-use
        tbl[6]  = '{6'b000010, 10'b0000_1000_00}; // branch
        tbl[7]  = '{6'b100010, 10'b1100_0100_00}; // load-use hides branch
        tbl[8]  = '{6'b001001, 10'b0000_1110_00}; // exception over memwait
        tbl[9]  = '{6'b011000, 10'b1111_0001_00}; // memwait over div start
        tbl[10] = '{6'b110000, 10'b1110_0010_10}; // div over load-use
        tbl[11] = '{6'b001010, 10'b1111_0001_00}; // memwait hides branch
        tbl[12] = '{6'b010001, 10'b0000_1110_00}; // exception over div start

        drive(6'b0);
        #2 check("reset_outputs", outs(), 10'b0);
        #10 reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            fresh_reset();
            drive(tbl[i].in);
            @(negedge clock);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Division: 32 stall cycles, then back in RUN.
        fresh_reset();
        c_pc = 0; c_busy = 0;
        for (int k = 0; k < 40; k++) begin
            drive(k == 0 ? 6'b010000 : 6'b0);
            @(negedge clock);
            if (bus.PC_Stall) c_pc++;
            if (bus.Div_Busy) c_busy++;
            @(posedge clock); #1;
        end
        check_int("div_pc_stall_cycles", c_pc, 32);
        check_int("div_busy_cycles", c_busy, 32);
        drive(6'b010000);
        @(negedge clock);
        check("div_restart_from_run", outs(), 10'b1110_0010_10);

        // Memory wait three cycles, then ready.
        fresh_reset();
        for (int k = 0; k < 4; k++) begin
            drive(k < 3 ? 6'b001000 : 6'b001100);
            @(negedge clock);
            check($sformatf("memwait_c%0d", k), outs(), k < 3 ? 10'b1111_0001_00 : 10'b0);
            @(posedge clock); #1;
        end

        // Exception during division cycle 10 aborts it.
        fresh_reset();
        for (int k = 0; k <= 11; k++) begin
            drive(k == 0 ? 6'b010000 : (k == 10 ? 6'b000001 : 6'b0));
            @(negedge clock);
            if (k == 10) check("div_exc_flush", outs() & 10'b1111_1111_01, 10'b0000_1110_00);
            if (k == 11) check("div_exc_after", outs(), 10'b0);
            @(posedge clock); #1;
        end
        drive(6'b010000);
        @(negedge clock);
        check("div_exc_state_run", outs(), 10'b1110_0010_10);

        // Reset mid-division clears everything.
        fresh_reset();
        for (int k = 0; k < 5; k++) begin
            drive(k == 0 ? 6'b010000 : 6'b0);
            @(posedge clock); #1;
        end
        reset = 1'b0;
        #1 check("div_reset_immediate", outs(), 10'b0);
        @(posedge clock); #1 reset = 1'b1;
        c_pc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (bus.PC_Stall) c_pc++;
        end
        check_int("div_reset_no_stall", c_pc, 0);

        // Long memory wait: timeout pulse only when the feature is built in.
        fresh_reset();
        c_err = 0; err_k = -1; err_out = '0;
        for (int k = 0; k < 300; k++) begin
            drive(6'b001000);
            @(negedge clock);
            if (bus.Bus_Error) begin
                c_err++;
                if (err_k < 0) begin err_k = k; err_out = outs(); end
            end
            @(posedge clock); #1;
        end
        drive(6'b0);
`ifdef PIPE_CTRL_TIMEOUT_EN
        check_int("timeout_pulses", c_err, 1);
        check_int("timeout_cycle", err_k, 255);
        check("timeout_flush", err_out, 10'b0000_1110_01);
`else
        check_int("timeout_pulses", c_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
